// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and stream/word widths.
package boot_loader_pkg;

    localparam int LEN_BYTES = 4;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/boot_loader_word_packer.sv
// Word packer: assembles stream bytes into one little-endian 32-bit word, lane by lane.
module boot_loader_word_packer
    import boot_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              insert,
    input  logic [1:0]        lane,
    input  logic              last,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    // An insert in the same cycle as a clear lands in an otherwise empty word.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W / BYTE_W; gi++) begin : g_lane
            logic [BYTE_W-1:0] lane_q;
            logic [BYTE_W-1:0] lane_d;

            always_comb begin
                lane_d = clear ? '0 : lane_q;
                if (insert && (lane == 2'(gi))) begin
                    lane_d = byte_in;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    lane_q <= '0;
                end else begin
                    lane_q <= lane_d;
                end
            end

            assign word[gi*BYTE_W +: BYTE_W] = lane_q;
        end
    endgenerate

    // True when the byte at this lane would finish the word.
    assign word_ready = last || (lane == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: takes a 4-byte length header plus payload, writes 32-bit words to
// instruction memory and holds the CPU in reset until the image is complete.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = $clog2(MEM_BYTES / 4)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WORD_W-1:0] mem_wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0]   MAX_LEN  = 32'(MEM_BYTES);
    localparam logic [31:0]   HDR_LAST = 32'(LEN_BYTES - 1);
    localparam logic [ADDR_W:0] WORD_ONE = (ADDR_W + 1)'(1);

    state_e          state_q, state_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [ADDR_W:0] words_q, words_d;
    logic            wr_en_q, wr_en_d;
    logic            last_q, last_d;

    logic        in_ready_c;
    logic [31:0] full_len;
    logic        pk_insert;
    logic        pk_clear;
    logic        pk_last;
    logic        pk_ready;

    assign pk_last = (cnt_q == len_q - 32'd1);

    boot_loader_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (pk_clear),
        .insert     (pk_insert),
        .lane       (cnt_q[1:0]),
        .last       (pk_last),
        .byte_in    (in_data),
        .word       (mem_wr_data),
        .word_ready (pk_ready)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        words_d    = words_q;
        wr_en_d    = 1'b0;
        last_d     = last_q;
        in_ready_c = 1'b0;
        pk_insert  = 1'b0;
        pk_clear   = wr_en_q;
        // Header arrives LSB first, so shifting in from the top leaves byte 0 in [7:0].
        full_len   = {in_data, len_q[31:8]};

        if (wr_en_q) begin
            words_d = words_q + WORD_ONE;
        end

        case (state_q)
            LEN: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    len_d = full_len;
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == HDR_LAST) begin
                        cnt_d = '0;
                        if (full_len == 32'd0) begin
                            state_d = DONE;
                        end else if (full_len > MAX_LEN) begin
                            state_d = ERROR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                // Stop accepting once the whole payload is in; only the final write remains.
                in_ready_c = (cnt_q != len_q);
                if (in_ready_c && in_valid) begin
                    pk_insert = 1'b1;
                    cnt_d     = cnt_q + 32'd1;
                    if (pk_ready) begin
                        wr_en_d = 1'b1;
                        last_d  = pk_last;
                    end
                end
                if (wr_en_q && last_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                if (start) begin
                    state_d  = LEN;
                    len_d    = '0;
                    cnt_d    = '0;
                    words_d  = '0;
                    last_d   = 1'b0;
                    pk_clear = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            wr_en_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            wr_en_q <= wr_en_d;
            last_q  <= last_d;
        end
    end

    assign in_ready     = in_ready_c;
    assign mem_wr_en    = wr_en_q;
    assign mem_wr_addr  = words_q[ADDR_W-1:0];
    assign words_loaded = words_q;
    assign cpu_reset    = (state_q != DONE);
    assign busy         = (state_q == LEN) || (state_q == DATA);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of complete loads plus hand sequences for stalls, reset and boundaries.
module tb_boot_loader;

    localparam int ADDR_W = 10;

    logic              clock;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    boot_loader #(.MEM_BYTES(4096)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]       len;
        logic [7:0]        n_pay;
        logic [15:0][7:0]  pay;
        logic [2:0]        n_wr;
        logic [3:0][31:0]  wdata;
        logic              exp_done;
        logic              exp_err;
    } vec_t;

    vec_t vecs [7];

    int errors = 0;
    int checks = 0;

    // Write log filled by the monitor; runs remember where they started.
    logic [ADDR_W-1:0] wa [256];
    logic [31:0]       wd [256];
    int                wr_cnt = 0;

    always @(negedge clock) begin
        if (mem_wr_en && wr_cnt < 256) begin
            wa[wr_cnt] = mem_wr_addr;
            wd[wr_cnt] = mem_wr_data;
            $display("write addr=%0d data=%08h", mem_wr_addr, mem_wr_data);
            wr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        end else begin
            @(posedge clock);
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] len);
        for (int k = 0; k < 4; k++) begin
            send_byte(len[8*k +: 8]);
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || error) && t < 20) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        base = wr_cnt;
        pulse_start();
        check($sformatf("v%0d start busy", idx), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d start clears", idx),
              {21'd0, words_loaded, done, error, cpu_reset}, {21'd0, 11'd0, 1'b0, 1'b0, 1'b1});
        send_header(v.len);
        if (v.n_pay == 8'd0) begin
            // Zero length and rejected headers settle right after the fourth header byte.
            check($sformatf("v%0d hdr done/err", idx), {30'd0, done, error}, {30'd0, v.exp_done, v.exp_err});
        end else begin
            for (int k = 0; k < int'(v.n_pay); k++) begin
                send_byte(v.pay[k]);
            end
            check($sformatf("v%0d final strobe", idx), {30'd0, mem_wr_en, cpu_reset}, 32'd3);
            wait_end();
        end
        check($sformatf("v%0d done", idx), {31'd0, done}, {31'd0, v.exp_done});
        check($sformatf("v%0d error", idx), {31'd0, error}, {31'd0, v.exp_err});
        check($sformatf("v%0d cpu_reset", idx), {31'd0, cpu_reset}, {31'd0, ~v.exp_done});
        check($sformatf("v%0d idle ports", idx), {30'd0, in_ready, busy}, 32'd0);
        check($sformatf("v%0d words_loaded", idx), {21'd0, words_loaded}, {29'd0, v.n_wr});
        check($sformatf("v%0d write count", idx), wr_cnt - base, {29'd0, v.n_wr});
        for (int i = 0; i < int'(v.n_wr); i++) begin
            check($sformatf("v%0d addr%0d", idx, i), {22'd0, wa[base+i]}, i);
            check($sformatf("v%0d data%0d", idx, i), wd[base+i], v.wdata[i]);
        end
        $display("load v%0d len=%08h writes=%0d done=%0b error=%0b", idx, v.len, wr_cnt - base, done, error);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vecs[0] = '{len: 32'd8, n_pay: 8'd8, pay: 128'h00a00593_00500513, n_wr: 3'd2,
                    wdata: {32'h0, 32'h0, 32'h00a00593, 32'h00500513}, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{len: 32'd6, n_pay: 8'd6, pay: 128'h6655_44332211, n_wr: 3'd2,
                    wdata: {32'h0, 32'h0, 32'h00006655, 32'h44332211}, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{len: 32'd0, n_pay: 8'd0, pay: 128'h0, n_wr: 3'd0,
                    wdata: 128'h0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{len: 32'h00001004, n_pay: 8'd0, pay: 128'h0, n_wr: 3'd0,
                    wdata: 128'h0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[4] = '{len: 32'd1, n_pay: 8'd1, pay: 128'hab, n_wr: 3'd1,
                    wdata: {32'h0, 32'h0, 32'h0, 32'h000000ab}, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{len: 32'h80000000, n_pay: 8'd0, pay: 128'h0, n_wr: 3'd0,
                    wdata: 128'h0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[6] = '{len: 32'h00001001, n_pay: 8'd0, pay: 128'h0, n_wr: 3'd0,
                    wdata: 128'h0, exp_done: 1'b0, exp_err: 1'b1};

        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clock);
        check("reset outputs", {26'd0, cpu_reset, busy, done, error, in_ready, mem_wr_en}, 32'h20);
        check("reset words", {21'd0, words_loaded}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Bytes offered in IDLE are ignored.
        in_valid = 1'b1;
        in_data  = 8'h5a;
        repeat (2) @(negedge clock);
        check("idle in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Stalled 16-byte payload with a stray start in the middle of DATA.
        base = wr_cnt;
        pulse_start();
        send_header(32'd16);
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            if (k == 6) begin
                pulse_start();
                check("mid start ignored", {30'd0, busy, in_ready}, 32'd3);
                check("mid start words", {21'd0, words_loaded}, 32'd1);
            end
            send_byte(8'(k));
        end
        wait_end();
        check("stall done", {31'd0, done}, 32'd1);
        check("stall write count", wr_cnt - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall addr%0d", i), {22'd0, wa[base+i]}, i);
            check($sformatf("stall data%0d", i), wd[base+i],
                  {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        end
        $display("load stall writes=%0d done=%0b", wr_cnt - base, done);
        in_valid = 1'b1;
        in_data  = 8'hff;
        repeat (3) @(negedge clock);
        check("done in_ready", {31'd0, in_ready}, 32'd0);
        check("done words kept", {21'd0, words_loaded}, 32'd4);
        check("done no extra writes", wr_cnt - base, 32'd4);
        in_valid = 1'b0;

        // Length of exactly MEM_BYTES is accepted.
        pulse_start();
        send_header(32'h00001000);
        check("max len accepted", {29'd0, error, busy, in_ready}, 32'd3);
        $display("load max-len header busy=%0b error=%0b", busy, error);

        // Asynchronous reset part-way through a payload.
        reset = 1'b0;
        #1;
        check("async reset outputs", {26'd0, cpu_reset, busy, done, error, in_ready, mem_wr_en}, 32'h20);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pulse_start();
        send_header(32'd8);
        for (int k = 0; k < 5; k++) begin
            send_byte(vecs[0].pay[k]);
        end
        check("pre-reset words", {21'd0, words_loaded}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid reset outputs", {26'd0, cpu_reset, busy, done, error, in_ready, mem_wr_en}, 32'h20);
        check("mid reset words", {21'd0, words_loaded}, 32'd0);
        check("mid reset data", mem_wr_data, 32'd0);
        $display("mid-load reset words_loaded=%0d cpu_reset=%0b", words_loaded, cpu_reset);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_vec(vecs[0], 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
